// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

endpackage

// File: rtl/ahbl_splitter_n_if.sv
// Bus bundle between the master, the splitter and its slave ports.
interface ahbl_splitter_n_if #(
    parameter int NUM_SLAVES = 5
);
    logic [31:0]              HADDR;
    logic [1:0]               HTRANS;
    logic                     HREADY;
    logic [31:0]              HRDATA;
    logic                     HRESP;
    logic [NUM_SLAVES-1:0]    S_HSEL;
    logic [NUM_SLAVES*32-1:0] S_HRDATA;
    logic [NUM_SLAVES-1:0]    S_HREADYOUT;
    logic [NUM_SLAVES-1:0]    S_HRESP;
    logic                     ERR_VALID;
    logic [31:0]              ERR_ADDR;
    logic                     ERR_CLR;

    // Splitter view: receives master requests and slave responses.
    modport slave (
        input  HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP, ERR_CLR,
        output HREADY, HRDATA, HRESP, S_HSEL, ERR_VALID, ERR_ADDR
    );

    modport master (
        output HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP, ERR_CLR,
        input  HREADY, HRDATA, HRESP, S_HSEL, ERR_VALID, ERR_ADDR
    );

endinterface

// File: rtl/ahbl_default_slave.sv
// Default slave answering unmapped NONSEQ/SEQ transfers with a two-cycle ERROR.
//   state   | meaning
//   DS_IDLE | zero-wait OKAY
//   DS_ERR1 | first ERROR cycle, HREADYOUT low
//   DS_ERR2 | second ERROR cycle, HREADYOUT high
module ahbl_default_slave
    import ahbl_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic       sel_none,
    output logic       HREADYOUT,
    output logic       HRESP
);

    ds_state_e state_q, state_d;
    logic      err_start;

    assign err_start = HREADY && sel_none &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state_q)
            DS_IDLE: begin
                if (err_start) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP   = HRESP_ERROR;
                state_d = err_start ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state_q <= DS_IDLE;
        else        state_q <= state_d;
    end

endmodule

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite address decoder and response mux for up to 16 slaves, with a
// built-in ERROR default slave and a sticky first-error capture register.
module ahbl_splitter_n
    import ahbl_pkg::*;
#(
    parameter int NUM_SLAVES = 5,
    parameter int DEC_LSB    = 28,
    parameter int DEC_BITS   = 4,
    parameter logic [NUM_SLAVES*DEC_BITS-1:0] SLAVE_IDS = {4'h6, 4'h8, 4'h4, 4'h2, 4'h0}
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahbl_splitter_n_if.slave  bus
);

    logic [DEC_BITS-1:0]   dec_field;
    logic [NUM_SLAVES-1:0] sel;
    logic [3:0]            sel_idx;
    logic                  sel_none;

    logic [3:0]  dsel_idx_q, dsel_idx_d;
    logic        dsel_def_q, dsel_def_d;

    logic        hready, hresp;
    logic [31:0] hrdata;
    logic        ds_hreadyout, ds_hresp;

    logic        err_event;
    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q, err_addr_d;

    assign dec_field = bus.HADDR[DEC_LSB +: DEC_BITS];

    // Scan from the top so the lowest matching slot is the one left standing.
    always_comb begin
        sel      = '0;
        sel_idx  = '0;
        sel_none = 1'b1;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (dec_field == SLAVE_IDS[i*DEC_BITS +: DEC_BITS]) begin
                sel      = '0;
                sel[i]   = 1'b1;
                sel_idx  = 4'(i);
                sel_none = 1'b0;
            end
        end
    end

    always_comb begin
        dsel_idx_d = dsel_idx_q;
        dsel_def_d = dsel_def_q;
        if (hready) begin
            dsel_idx_d = sel_idx;
            dsel_def_d = sel_none;
        end
    end

    always_comb begin
        hready = ds_hreadyout;
        hresp  = ds_hresp;
        hrdata = '0;
        if (!dsel_def_q) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dsel_idx_q == 4'(i)) begin
                    hready = bus.S_HREADYOUT[i];
                    hresp  = bus.S_HRESP[i];
                    hrdata = bus.S_HRDATA[32*i +: 32];
                end
            end
        end
    end

    ahbl_default_slave u_default (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (hready),
        .HTRANS    (bus.HTRANS),
        .sel_none  (sel_none),
        .HREADYOUT (ds_hreadyout),
        .HRESP     (ds_hresp)
    );

    // Same condition that sends the default slave into ERR1.
    assign err_event = hready && sel_none &&
                       ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_event && (!err_valid_q || bus.ERR_CLR)) begin
            err_valid_d = 1'b1;
            err_addr_d  = bus.HADDR;
        end else if (bus.ERR_CLR) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_idx_q  <= '0;
            dsel_def_q  <= 1'b1;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            dsel_idx_q  <= dsel_idx_d;
            dsel_def_q  <= dsel_def_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign bus.S_HSEL    = sel;
    assign bus.HREADY    = hready;
    assign bus.HRESP     = hresp;
    assign bus.HRDATA    = hrdata;
    assign bus.ERR_VALID = err_valid_q;
    assign bus.ERR_ADDR  = err_addr_q;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Bench for ahbl_splitter_n: decode table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_ahbl_splitter_n;
    import ahbl_pkg::*;

    logic HCLK;
    logic HRESET;
    int   checks = 0;
    int   errors = 0;

    ahbl_splitter_n_if #(.NUM_SLAVES(5)) bus ();
    ahbl_splitter_n_if #(.NUM_SLAVES(2)) bus2 ();

    ahbl_splitter_n dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

    ahbl_splitter_n #(
        .NUM_SLAVES (2),
        .DEC_LSB    (28),
        .DEC_BITS   (4),
        .SLAVE_IDS  (8'h00)
    ) dut2 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus2));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  sel;
    } dec_vec_t;

    dec_vec_t tv[10];
    int       ids[5] = '{0, 2, 4, 8, 6};

    // reference model state
    int          m_tgt;
    int          m_err;
    logic        m_valid;
    logic [31:0] m_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dec_ref(input logic [31:0] a);
        int idx = -1;
        for (int i = 0; i < 5; i++)
            if (idx < 0 && ids[i] == int'(a[31:28])) idx = i;
        return idx;
    endfunction

    task automatic slaves_default();
        for (int i = 0; i < 5; i++) bus.S_HRDATA[32*i +: 32] = 32'h5100_0000 + 32'(i);
        bus.S_HREADYOUT = '1;
        bus.S_HRESP     = '0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        @(negedge HCLK);
        bus.HADDR  = a;
        bus.HTRANS = t;
        #1;
    endtask

    task automatic resp_chk(input string nm, input logic rdy, input logic rsp);
        chk({nm, "_rdy"}, 32'(bus.HREADY), 32'(rdy));
        chk({nm, "_rsp"}, 32'(bus.HRESP), 32'(rsp));
    endtask

    logic        e_rdy, e_rsp, acc, clr, cap;
    logic [31:0] e_dat, a;
    logic [1:0]  tr;
    int          t;

    initial begin
        tv[0] = '{32'h0000_0000, 5'b00001};
        tv[1] = '{32'h2000_0010, 5'b00010};
        tv[2] = '{32'h4123_4567, 5'b00100};
        tv[3] = '{32'h8FFF_FFFF, 5'b01000};
        tv[4] = '{32'h6000_0000, 5'b10000};
        tv[5] = '{32'h6FFF_FFFC, 5'b10000};
        tv[6] = '{32'h7000_0000, 5'b00000};
        tv[7] = '{32'hF000_0000, 5'b00000};
        tv[8] = '{32'h1FFF_FFFF, 5'b00000};
        tv[9] = '{32'hA000_0004, 5'b00000};

        HRESET       = 1'b1;
        bus.HADDR    = '0;
        bus.HTRANS   = HTRANS_IDLE;
        bus.ERR_CLR  = 1'b0;
        slaves_default();
        bus2.HADDR       = '0;
        bus2.HTRANS      = HTRANS_IDLE;
        bus2.ERR_CLR     = 1'b0;
        bus2.S_HRDATA    = '0;
        bus2.S_HREADYOUT = '1;
        bus2.S_HRESP     = '0;
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        resp_chk("reset", 1'b1, 1'b0);
        chk("reset_rdata", bus.HRDATA, 32'h0);
        chk("reset_evalid", 32'(bus.ERR_VALID), 32'h0);
        chk("reset_eaddr", bus.ERR_ADDR, 32'h0);

        for (int i = 0; i < 10; i++) begin
            drive(tv[i].addr, HTRANS_IDLE);
            chk($sformatf("dec_tv%0d", i), 32'(bus.S_HSEL), 32'(tv[i].sel));
        end

        // read from slave 1
        drive(32'h2000_0010, HTRANS_NONSEQ);
        chk("rd_hsel", 32'(bus.S_HSEL), 32'h2);
        @(negedge HCLK);
        bus.HADDR  = '0;
        bus.HTRANS = HTRANS_IDLE;
        bus.S_HRDATA[63:32] = 32'hDEAD_BEEF;
        #1;
        chk("rd_data", bus.HRDATA, 32'hDEAD_BEEF);
        resp_chk("rd", 1'b1, 1'b0);
        slaves_default();

        // slave 3 stalls three cycles while the next address moves to 0
        drive(32'h8000_0000, HTRANS_NONSEQ);
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            bus.HADDR  = '0;
            bus.HTRANS = HTRANS_NONSEQ;
            bus.S_HREADYOUT[3] = 1'b0;
            #1;
            chk($sformatf("stall%0d_rdy", k), 32'(bus.HREADY), 32'h0);
            chk($sformatf("stall%0d_dat", k), bus.HRDATA, 32'h5100_0003);
        end
        @(negedge HCLK);
        bus.S_HREADYOUT[3] = 1'b1;
        #1;
        chk("stall_end_rdy", 32'(bus.HREADY), 32'h1);
        chk("stall_end_dat", bus.HRDATA, 32'h5100_0003);
        drive(32'h0000_0000, HTRANS_IDLE);
        chk("after_stall_dat", bus.HRDATA, 32'h5100_0000);

        // single unmapped NONSEQ
        drive(32'hA000_0004, HTRANS_NONSEQ);
        drive(32'h0000_0000, HTRANS_IDLE);
        resp_chk("err1", 1'b0, 1'b1);
        drive(32'h0000_0000, HTRANS_IDLE);
        resp_chk("err2", 1'b1, 1'b1);
        chk("err_valid", 32'(bus.ERR_VALID), 32'h1);
        chk("err_addr", bus.ERR_ADDR, 32'hA000_0004);

        // IDLE to unmapped space is a plain OKAY
        drive(32'hA000_0000, HTRANS_IDLE);
        drive(32'h0000_0000, HTRANS_IDLE);
        resp_chk("idle_unmap", 1'b1, 1'b0);
        chk("idle_evalid", 32'(bus.ERR_VALID), 32'h1);
        chk("idle_eaddr", bus.ERR_ADDR, 32'hA000_0004);

        @(negedge HCLK);
        bus.ERR_CLR = 1'b1;
        @(negedge HCLK);
        bus.ERR_CLR = 1'b0;
        #1;
        chk("clr_evalid", 32'(bus.ERR_VALID), 32'h0);

        // back-to-back errors, then clear coinciding with a third capture
        drive(32'hA000_0000, HTRANS_NONSEQ);
        drive(32'hC000_0000, HTRANS_NONSEQ);
        resp_chk("b2b_a1", 1'b0, 1'b1);
        drive(32'hC000_0000, HTRANS_NONSEQ);
        resp_chk("b2b_a2", 1'b1, 1'b1);
        chk("b2b_eaddr_a", bus.ERR_ADDR, 32'hA000_0000);
        drive(32'hE000_0000, HTRANS_NONSEQ);
        resp_chk("b2b_c1", 1'b0, 1'b1);
        @(negedge HCLK);
        bus.ERR_CLR = 1'b1;
        #1;
        resp_chk("b2b_c2", 1'b1, 1'b1);
        chk("b2b_eaddr_c", bus.ERR_ADDR, 32'hA000_0000);
        @(negedge HCLK);
        bus.ERR_CLR = 1'b0;
        bus.HADDR   = '0;
        bus.HTRANS  = HTRANS_IDLE;
        #1;
        resp_chk("b2b_e1", 1'b0, 1'b1);
        chk("clrcap_valid", 32'(bus.ERR_VALID), 32'h1);
        chk("clrcap_addr", bus.ERR_ADDR, 32'hE000_0000);
        drive(32'h0000_0000, HTRANS_IDLE);
        resp_chk("b2b_e2", 1'b1, 1'b1);
        drive(32'h0000_0000, HTRANS_IDLE);
        resp_chk("b2b_done", 1'b1, 1'b0);

        // duplicate IDs on the two-slave build
        @(negedge HCLK);
        bus2.HADDR = 32'h0000_0000;
        #1;
        chk("dup_hsel0", 32'(bus2.S_HSEL), 32'h1);
        bus2.HADDR = 32'h1000_0000;
        #1;
        chk("dup_hsel_none", 32'(bus2.S_HSEL), 32'h0);

        // asynchronous reset in the middle of an ERROR response
        drive(32'hA000_0008, HTRANS_NONSEQ);
        @(posedge HCLK);
        #2;
        HRESET     = 1'b1;
        bus.HTRANS = HTRANS_IDLE;
        #1;
        resp_chk("async_rst", 1'b1, 1'b0);
        chk("async_rst_ev", 32'(bus.ERR_VALID), 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;

        m_tgt = -1; m_err = 0; m_valid = 1'b0; m_addr = '0;
        for (int n = 0; n < 600; n++) begin
            @(negedge HCLK);
            bus.HADDR   = $urandom;
            bus.HTRANS  = 2'($urandom_range(0, 3));
            bus.ERR_CLR = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 5; i++) begin
                bus.S_HRDATA[32*i +: 32] = $urandom;
                bus.S_HREADYOUT[i]       = ($urandom_range(0, 3) != 0);
                bus.S_HRESP[i]           = 1'($urandom_range(0, 1));
            end
            #1;
            if (m_tgt >= 0) begin
                e_rdy = bus.S_HREADYOUT[m_tgt];
                e_rsp = bus.S_HRESP[m_tgt];
                e_dat = bus.S_HRDATA[32*m_tgt +: 32];
            end else begin
                e_rdy = (m_err != 1);
                e_rsp = (m_err != 0);
                e_dat = '0;
            end
            a  = bus.HADDR;
            tr = bus.HTRANS;
            t  = dec_ref(a);
            chk("rnd_hsel", 32'(bus.S_HSEL), (t < 0) ? 32'h0 : (32'h1 << t));
            chk("rnd_rdy", 32'(bus.HREADY), 32'(e_rdy));
            chk("rnd_rsp", 32'(bus.HRESP), 32'(e_rsp));
            chk("rnd_dat", bus.HRDATA, e_dat);
            chk("rnd_evalid", 32'(bus.ERR_VALID), 32'(m_valid));
            chk("rnd_eaddr", bus.ERR_ADDR, m_addr);
            acc = e_rdy;
            clr = bus.ERR_CLR;
            @(posedge HCLK);
            cap = acc && (t < 0) && tr[1];
            if (acc) begin
                m_tgt = t;
                m_err = cap ? 1 : 0;
            end else if (m_err == 1) begin
                m_err = 2;
            end
            if (cap && (!m_valid || clr)) begin
                m_valid = 1'b1;
                m_addr  = a;
            end else if (clr) begin
                m_valid = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
